ctrl_pipe: RTL and testbench

Parametrised control-signal pipeline for the ARM-style core. It carries decoded control bundles from Decode through NSTAGES post-decode stages (stage 0 = Execute, last = Writeback). It evaluates condition codes in Execute against an architectural flags register (N,Z,C,V,Q) and gates register, memory and PC writes. Unlike the fixed-depth predecessor, it adds per-stage stall and flush, a sticky Q flag, and configurable depth and bundle width.

---
 rtl/ctrl_pipe_pkg.sv | 34 +++
 rtl/ctrl_cond_eval.sv | 44 ++++
 rtl/ctrl_pipe.sv | 190 +++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-signal pipeline: ARM condition codes,
// flag bit positions inside the {N,Z,C,V,Q} flags word, and flagwrite bits.
package ctrl_pipe_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Q = 0;

  localparam int unsigned FW_NZ = 2;
  localparam int unsigned FW_CV = 1;
  localparam int unsigned FW_Q  = 0;

endpackage

// File: rtl/ctrl_cond_eval.sv
// Combinational ARM condition-code evaluator. Used in Execute; also usable
// in Decode for early branch resolution against flags_next.
module ctrl_cond_eval
  import ctrl_pipe_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  logic unusedQ;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  // Q does not participate in any condition.
  assign unusedQ = flags[FLAG_Q];

  // Decode the condition field against the current flags; NV never passes.
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline from Decode through NSTAGES post-decode stages
// (stage 0 = Execute, last = Writeback) with per-stage stall/flush,
// Execute condition gating and the architectural {N,Z,C,V,Q} flags.
// Optional retire/squash counters are enabled by defining CTRL_PIPE_PERF_EN.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned CTRL_W  = 16,
  parameter int unsigned NSTAGES = 3,
  parameter int unsigned FLAG_W  = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_d,
  input  logic [CTRL_W-1:0]           ctrl_d,
  input  logic                        regwrite_d,
  input  logic                        memwrite_d,
  input  logic                        pcsrc_d,
  input  logic                        nowrite_d,
  input  logic [3:0]                  cond_d,
  input  logic [2:0]                  flagwrite_d,
  input  logic [NSTAGES-1:0]          stall,
  input  logic [NSTAGES-1:0]          flush,
  input  logic [FLAG_W-1:0]           alu_flags_e,
  output logic [NSTAGES*CTRL_W-1:0]   ctrl_q,
  output logic [NSTAGES-1:0]          valid_q,
  output logic [NSTAGES-1:0]          regwrite_q,
  output logic [NSTAGES-1:0]          memwrite_q,
  output logic [NSTAGES-1:0]          pcsrc_q,
  output logic                        condex_e,
  output logic [FLAG_W-1:0]           flags,
  output logic [FLAG_W-1:0]           flags_next,
  output logic                        pc_wr_pending
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]                 retired_cnt,
  output logic [31:0]                 squashed_cnt
`endif
);

  logic [NSTAGES-1:0] hold;
  logic [NSTAGES-1:0] holdPrev;
  logic [NSTAGES-1:0] fwdRegwrite, fwdMemwrite, fwdPcsrc;
  logic [NSTAGES-1:0] validIn, regwriteIn, memwriteIn, pcsrcIn;
  logic [CTRL_W-1:0]  ctrlR  [NSTAGES];
  logic [CTRL_W-1:0]  ctrlIn [NSTAGES];
  logic [3:0]         condE;
  logic               nowriteE;
  logic [2:0]         flagwriteE;
  logic               condPass;
  logic               flagUpd;

  ctrl_cond_eval uCondEval (
    .cond  (condE),
    .flags (flags),
    .pass  (condPass)
  );

  assign condex_e = condPass & valid_q[0];

  // A stage holds when it or any older stage is stalled.
  always_comb begin
    hold = '0;
    for (int unsigned k = 0; k < NSTAGES; k++) begin
      hold[k] = |(stall >> k);
    end
  end

  // Decode acts as stage -1: the source vectors are shifted by one so each
  // stage reads its predecessor; Execute's enables are condition-gated here.
  always_comb begin
    fwdRegwrite    = regwrite_q;
    fwdMemwrite    = memwrite_q;
    fwdPcsrc       = pcsrc_q;
    fwdRegwrite[0] = regwrite_q[0] & condex_e & ~nowriteE;
    fwdMemwrite[0] = memwrite_q[0] & condex_e;
    fwdPcsrc[0]    = pcsrc_q[0] & condex_e;
    holdPrev   = {hold[NSTAGES-2:0], 1'b0};
    validIn    = {valid_q[NSTAGES-2:0], valid_d};
    regwriteIn = {fwdRegwrite[NSTAGES-2:0], regwrite_d & valid_d};
    memwriteIn = {fwdMemwrite[NSTAGES-2:0], memwrite_d & valid_d};
    pcsrcIn    = {fwdPcsrc[NSTAGES-2:0], pcsrc_d & valid_d};
    ctrlIn[0]  = ctrl_d;
    for (int unsigned k = 1; k < NSTAGES; k++) begin
      ctrlIn[k] = ctrlR[k-1];
    end
    // A held predecessor leaves a bubble behind in an advancing stage.
    for (int unsigned k = 0; k < NSTAGES; k++) begin
      if (holdPrev[k]) begin
        validIn[k]    = 1'b0;
        regwriteIn[k] = 1'b0;
        memwriteIn[k] = 1'b0;
        pcsrcIn[k]    = 1'b0;
        ctrlIn[k]     = '0;
      end
    end
  end

  // Flags update only for a valid, passing instruction leaving Execute.
  always_comb begin
    flagUpd    = valid_q[0] & condex_e & ~hold[0] & ~flush[0];
    flags_next = flags;
    if (flagUpd) begin
      if (flagwriteE[FW_NZ]) begin
        flags_next[FLAG_N] = alu_flags_e[FLAG_N];
        flags_next[FLAG_Z] = alu_flags_e[FLAG_Z];
      end
      if (flagwriteE[FW_CV]) begin
        flags_next[FLAG_C] = alu_flags_e[FLAG_C];
        flags_next[FLAG_V] = alu_flags_e[FLAG_V];
      end
      if (flagwriteE[FW_Q]) begin
        flags_next[FLAG_Q] = flags[FLAG_Q] | alu_flags_e[FLAG_Q];
      end
    end
  end

  // Flatten per-stage bundles onto the output bus.
  always_comb begin
    ctrl_q = '0;
    for (int unsigned k = 0; k < NSTAGES; k++) begin
      ctrl_q[k*CTRL_W +: CTRL_W] = ctrlR[k];
    end
  end

  assign pc_wr_pending = (valid_d & pcsrc_d) | (|pcsrc_q[NSTAGES-2:0]);

  // Stage registers and flags: reset, then flush over hold over advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      memwrite_q <= '0;
      pcsrc_q    <= '0;
      for (int unsigned k = 0; k < NSTAGES; k++) begin
        ctrlR[k] <= '0;
      end
      condE      <= '0;
      nowriteE   <= 1'b0;
      flagwriteE <= '0;
      flags      <= '0;
    end else begin
      for (int unsigned k = 0; k < NSTAGES; k++) begin
        if (flush[k]) begin
          valid_q[k]    <= 1'b0;
          regwrite_q[k] <= 1'b0;
          memwrite_q[k] <= 1'b0;
          pcsrc_q[k]    <= 1'b0;
          ctrlR[k]      <= '0;
        end else if (!hold[k]) begin
          valid_q[k]    <= validIn[k];
          regwrite_q[k] <= regwriteIn[k];
          memwrite_q[k] <= memwriteIn[k];
          pcsrc_q[k]    <= pcsrcIn[k];
          ctrlR[k]      <= ctrlIn[k];
        end
      end
      if (flush[0]) begin
        condE      <= '0;
        nowriteE   <= 1'b0;
        flagwriteE <= '0;
      end else if (!hold[0]) begin
        condE      <= cond_d;
        nowriteE   <= nowrite_d & valid_d;
        flagwriteE <= flagwrite_d & {3{valid_d}};
      end
      flags <= flags_next;
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  // Retire and squash event counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt  <= '0;
      squashed_cnt <= '0;
    end else begin
      if (valid_q[NSTAGES-1] & ~hold[NSTAGES-1]) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if (valid_q[0] & ~condex_e & ~hold[0]) begin
        squashed_cnt <= squashed_cnt + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe (NSTAGES=3, CTRL_W=16): a vector table
// of back-to-back instructions with a W-stage scoreboard, followed by
// hand-written reset, pc_wr_pending, stall and flush sequences.
module tb_ctrl_pipe;

  localparam int unsigned CW = 16;
  localparam int unsigned NS = 3;
  localparam int NV = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_d;
  logic [CW-1:0]   ctrl_d;
  logic            regwrite_d, memwrite_d, pcsrc_d, nowrite_d;
  logic [3:0]      cond_d;
  logic [2:0]      flagwrite_d;
  logic [NS-1:0]   stall, flush;
  logic [4:0]      alu_flags_e;
  logic [NS*CW-1:0] ctrl_q;
  logic [NS-1:0]   valid_q, regwrite_q, memwrite_q, pcsrc_q;
  logic            condex_e;
  logic [4:0]      flags, flags_next;
  logic            pc_wr_pending;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.CTRL_W(CW), .NSTAGES(NS), .FLAG_W(5)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .ctrl_d(ctrl_d),
    .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .pcsrc_d(pcsrc_d),
    .nowrite_d(nowrite_d), .cond_d(cond_d), .flagwrite_d(flagwrite_d),
    .stall(stall), .flush(flush), .alu_flags_e(alu_flags_e),
    .ctrl_q(ctrl_q), .valid_q(valid_q), .regwrite_q(regwrite_q),
    .memwrite_q(memwrite_q), .pcsrc_q(pcsrc_q), .condex_e(condex_e),
    .flags(flags), .flags_next(flags_next), .pc_wr_pending(pc_wr_pending)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  cond;
    logic        rw, mw, pc, nw;
    logic [2:0]  fw;
    logic [4:0]  alu;
    logic [15:0] ctrl;
    logic        eCx, eRw, eMw, ePc;
    logic [4:0]  eFl;
  } vec_t;

  typedef struct {
    logic [15:0] ctrl;
    logic        rw, mw, pc;
  } sb_t;

  vec_t vecs [NV];
  sb_t  sbq [$];

  function automatic vec_t mkVec(input logic v, input logic [3:0] c,
      input logic rw, input logic mw, input logic pc, input logic nw,
      input logic [2:0] fw, input logic [4:0] alu, input logic [15:0] ct,
      input logic eCx, input logic eRw, input logic eMw, input logic ePc,
      input logic [4:0] eFl);
    vec_t r;
    r.valid = v; r.cond = c; r.rw = rw; r.mw = mw; r.pc = pc; r.nw = nw;
    r.fw = fw; r.alu = alu; r.ctrl = ct;
    r.eCx = eCx; r.eRw = eRw; r.eMw = eMw; r.ePc = ePc; r.eFl = eFl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic rw,
      input logic mw, input logic pc, input logic nw, input logic [2:0] fw,
      input logic [15:0] ct);
    valid_d = v; cond_d = c; regwrite_d = rw; memwrite_d = mw;
    pcsrc_d = pc; nowrite_d = nw; flagwrite_d = fw; ctrl_d = ct;
  endtask

  task automatic idle();
    drive(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // valid cond rw mw pc nw fw alu ctrl | condex rw1 mw1 pc1 flags
    vecs[0]  = mkVec(1, 4'hE, 1,0,0,0, 3'b000, 5'b00000, 16'h1000, 1,1,0,0, 5'b00000);
    vecs[1]  = mkVec(1, 4'hE, 1,0,0,1, 3'b110, 5'b01100, 16'h1001, 1,0,0,0, 5'b01100);
    vecs[2]  = mkVec(1, 4'h0, 1,1,0,0, 3'b000, 5'b00000, 16'h1002, 1,1,1,0, 5'b01100);
    vecs[3]  = mkVec(1, 4'h1, 1,1,0,0, 3'b110, 5'b10011, 16'h1003, 0,0,0,0, 5'b01100);
    vecs[4]  = mkVec(1, 4'h8, 0,0,1,0, 3'b000, 5'b00000, 16'h1004, 0,0,0,0, 5'b01100);
    vecs[5]  = mkVec(1, 4'h9, 0,0,1,0, 3'b001, 5'b00001, 16'h1005, 1,0,0,1, 5'b01101);
    vecs[6]  = mkVec(1, 4'hE, 1,0,0,0, 3'b111, 5'b10010, 16'h1006, 1,1,0,0, 5'b10011);
    vecs[7]  = mkVec(1, 4'hA, 1,0,0,0, 3'b000, 5'b00000, 16'h1007, 1,1,0,0, 5'b10011);
    vecs[8]  = mkVec(1, 4'hB, 1,0,0,0, 3'b000, 5'b00000, 16'h1008, 0,0,0,0, 5'b10011);
    vecs[9]  = mkVec(1, 4'hC, 0,1,0,0, 3'b000, 5'b00000, 16'h1009, 1,0,1,0, 5'b10011);
    vecs[10] = mkVec(1, 4'hD, 0,1,0,0, 3'b000, 5'b00000, 16'h100A, 0,0,0,0, 5'b10011);
    vecs[11] = mkVec(1, 4'hF, 1,1,1,0, 3'b000, 5'b00000, 16'h100B, 0,0,0,0, 5'b10011);
    vecs[12] = mkVec(0, 4'hE, 1,1,1,0, 3'b111, 5'b11111, 16'h100C, 0,0,0,0, 5'b10011);
    vecs[13] = mkVec(1, 4'h4, 1,0,0,0, 3'b111, 5'b00000, 16'h100D, 1,1,0,0, 5'b00001);
    vecs[14] = mkVec(1, 4'h5, 1,0,0,0, 3'b000, 5'b00000, 16'h100E, 1,1,0,0, 5'b00001);
    vecs[15] = mkVec(1, 4'h2, 1,0,0,0, 3'b000, 5'b00000, 16'h100F, 0,0,0,0, 5'b00001);
    vecs[16] = mkVec(1, 4'h3, 1,0,0,0, 3'b000, 5'b00000, 16'h1010, 1,1,0,0, 5'b00001);
    vecs[17] = mkVec(1, 4'h6, 1,0,0,0, 3'b000, 5'b00000, 16'h1011, 0,0,0,0, 5'b00001);
    vecs[18] = mkVec(1, 4'h7, 1,0,0,0, 3'b001, 5'b00000, 16'h1012, 1,1,0,0, 5'b00001);
    vecs[19] = mkVec(1, 4'h0, 1,0,0,0, 3'b000, 5'b00000, 16'h1013, 0,0,0,0, 5'b00001);

    reset = 1'b1; stall = '0; flush = '0; alu_flags_e = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rstValid", 32'(valid_q), 0);
    chk("rstRegwrite", 32'(regwrite_q), 0);
    chk("rstMemPc", 32'({memwrite_q, pcsrc_q}), 0);
    chk("rstFlags", 32'(flags), 0);
    chk("rstCtrl", 32'(ctrl_q[31:0]), 0);

    // Back-to-back table: instruction c is in Execute during cycle c+1,
    // in stage 1 during c+2 and in Writeback during c+3.
    for (int c = 0; c <= NV + 2; c++) begin
      if (c < NV)
        drive(vecs[c].valid, vecs[c].cond, vecs[c].rw, vecs[c].mw,
              vecs[c].pc, vecs[c].nw, vecs[c].fw, vecs[c].ctrl);
      else
        idle();
      alu_flags_e = (c >= 1 && c - 1 < NV) ? vecs[c-1].alu : 5'b00000;
      #1;
      if (c >= 1 && c - 1 < NV) begin
        chk($sformatf("v%0d condex_e", c-1), 32'(condex_e), 32'(vecs[c-1].eCx));
        chk($sformatf("v%0d flags_next", c-1), 32'(flags_next), 32'(vecs[c-1].eFl));
        chk($sformatf("v%0d valid_q0", c-1), 32'(valid_q[0]), 32'(vecs[c-1].valid));
        chk($sformatf("v%0d regwrite_q0", c-1), 32'(regwrite_q[0]),
            32'(vecs[c-1].valid & vecs[c-1].rw));
      end
      if (c >= 2 && c - 2 < NV) begin
        chk($sformatf("v%0d gated1", c-2), 32'({regwrite_q[1], memwrite_q[1], pcsrc_q[1]}),
            32'({vecs[c-2].eRw, vecs[c-2].eMw, vecs[c-2].ePc}));
        chk($sformatf("v%0d flags", c-2), 32'(flags), 32'(vecs[c-2].eFl));
      end
      if (valid_q[2]) begin
        if (sbq.size() == 0) begin
          chk("sbUnderflow", 32'(valid_q[2]), 0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk($sformatf("W ctrl %0h", e.ctrl), 32'(ctrl_q[47:32]), 32'(e.ctrl));
          chk($sformatf("W enables %0h", e.ctrl),
              32'({regwrite_q[2], memwrite_q[2], pcsrc_q[2]}), 32'({e.rw, e.mw, e.pc}));
        end
      end
      if (c < NV && vecs[c].valid) begin
        sb_t s;
        s.ctrl = vecs[c].ctrl; s.rw = vecs[c].eRw; s.mw = vecs[c].eMw; s.pc = vecs[c].ePc;
        sbq.push_back(s);
      end
      tick();
    end
    chk("sbDrain", 32'(sbq.size()), 0);
    alu_flags_e = '0;

    // Reset with three instructions in flight; sticky Q must clear.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hE, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 16'hA000 + 16'(i));
      tick();
    end
    #1;
    chk("midValid", 32'(valid_q), 32'h7);
    chk("midQ", 32'(flags), 32'h01);
    reset = 1'b1;
    stall = 3'b111;
    tick();
    reset = 1'b0;
    stall = '0;
    idle();
    #1;
    chk("midRstValid", 32'(valid_q), 0);
    chk("midRstWrites", 32'({regwrite_q, memwrite_q, pcsrc_q}), 0);
    chk("midRstFlags", 32'(flags), 0);
    chk("midRstCtrl", 32'(ctrl_q[47:32]), 0);

    // pc_wr_pending tracks a PC write until it reaches Writeback.
    drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 16'hBEEF);
    #1;
    chk("pcPend0", 32'(pc_wr_pending), 1);
    tick(); idle(); #1;
    chk("pcPend1", 32'(pc_wr_pending), 1);
    tick(); #1;
    chk("pcPend2", 32'(pc_wr_pending), 1);
    tick(); #1;
    chk("pcPend3", 32'(pc_wr_pending), 0);
    chk("pcAtW", 32'({valid_q[2], pcsrc_q[2]}), 32'h3);
    chk("pcCtrlW", 32'(ctrl_q[47:32]), 32'hBEEF);

    // stall[1] for two cycles: stages 0/1 hold, Writeback sees bubbles.
    drive(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'h00A1);
    tick();
    drive(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'h00B2);
    tick();
    drive(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'h00C3);
    stall = 3'b010;
    tick();
    idle();
    #1;
    chk("stall1Ctrl", 32'(ctrl_q[31:0]), 32'h00A1_00B2);
    chk("stall1Valid", 32'(valid_q), 32'h3);
    tick();
    stall = '0;
    #1;
    chk("stall2Ctrl", 32'(ctrl_q[31:0]), 32'h00A1_00B2);
    chk("stall2Valid", 32'(valid_q), 32'h3);
    tick(); #1;
    chk("releaseCtrl", 32'(ctrl_q[47:16]), 32'h00A1_00B2);
    chk("releaseValid", 32'(valid_q), 32'h6);
    chk("releaseRwW", 32'(regwrite_q[2]), 1);

    // flush[0] together with stall[0]: Execute becomes a bubble, no flag update.
    drive(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 16'h00D4);
    tick();
    idle();
    stall = 3'b001;
    flush = 3'b001;
    alu_flags_e = 5'b11110;
    #1;
    chk("flushCondex", 32'(condex_e), 1);
    chk("flushFlagsNext", 32'(flags_next), 0);
    tick();
    stall = '0;
    flush = '0;
    alu_flags_e = '0;
    #1;
    chk("flushValid0", 32'(valid_q[0]), 0);
    chk("flushRw0", 32'(regwrite_q[0]), 0);
    chk("flushCtrl0", 32'(ctrl_q[15:0]), 0);
    chk("flushBubble1", 32'(valid_q[1]), 0);
    chk("flushFlags", 32'(flags), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
